mathbox_host_if: RTL and testbench

- CPU-side front end of the Math Box.
- Decodes 6502 writes into a Math Box program start: latches the 8-bit operand for the ALU, loads the microprogram start address and drives begin_n low to release the sequencer.
- Tracks the busy/done state from the sequencer's pcen_n feedback, with a watchdog timeout.
- Latches the 16-bit ALU result and serves the status, result-low and result-high reads back to the CPU.

---
 rtl/mathbox_pkg.sv | 25 ++
 rtl/mathbox_watchdog.sv | 41 ++++
 rtl/mathbox_host_if.sv | 170 +++++++++++++++++
 tb/tb_mathbox_host_if.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mathbox_pkg.sv
// Shared definitions for the Math Box CPU front end: FSM states, CPU register
// offsets, the command window decode and status bit positions.
package mathbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_SETTLE = 2'd3
  } mb_state_e;

  localparam logic [6:0] MB_STATUS   = 7'h40;
  localparam logic [6:0] MB_RES_LO   = 7'h60;
  localparam logic [6:0] MB_RES_HI   = 7'h70;
  localparam logic [6:0] MB_CMD_MASK = 7'h60;

  localparam int STAT_BUSY_BIT    = 7;
  localparam int STAT_TIMEOUT_BIT = 6;

  // Offsets 0x00-0x1F start a program; the low bits are the start address.
  function automatic logic is_cmd(input logic [6:0] addr);
    return (addr & MB_CMD_MASK) == 7'h00;
  endfunction

endpackage

// File: rtl/mathbox_watchdog.sv
// Saturating run-cycle counter; term flags the cycle whose update reaches
// all-ones so the FSM can leave RUN on that same edge.
module mathbox_watchdog #(
  parameter int TIMEOUT_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  output logic [TIMEOUT_W-1:0] cnt,
  output logic                 term
);

  logic [TIMEOUT_W-1:0] cnt_d;
  logic [TIMEOUT_W-1:0] cnt_q;

  // Next count: clear wins, then a saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {TIMEOUT_W{1'b0}};
    end else if (en && (cnt_q != {TIMEOUT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {TIMEOUT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_d == {TIMEOUT_W{1'b1}});

endmodule

// File: rtl/mathbox_host_if.sv
// CPU-side front end of the Math Box: starts microprograms on command writes,
// tracks busy/timeout from the sequencer and serves status/result reads.
module mathbox_host_if
  import mathbox_pkg::*;
#(
  parameter int TIMEOUT_W = 10,
  parameter int START_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         cpu_addr,
  input  logic [7:0]         cpu_din,
  input  logic               cpu_we,
  input  logic               cpu_re,
  output logic [7:0]         cpu_dout,
  output logic [7:0]         alu_din,
  output logic               pc_load,
  output logic [START_W-1:0] pc_start,
  output logic               begin_n,
  input  logic               pcen_n,
  input  logic [15:0]        alu_result,
  output logic               busy,
  output logic               timeout
);

  mb_state_e            state_d, state_q;
  logic [7:0]           cpu_dout_d, cpu_dout_q;
  logic [7:0]           alu_din_d, alu_din_q;
  logic [START_W-1:0]   pc_start_d, pc_start_q;
  logic                 pc_load_d, pc_load_q;
  logic                 begin_n_d, begin_n_q;
  logic                 busy_d, busy_q;
  logic                 timeout_d, timeout_q;
  logic [15:0]          result_d, result_q;
  logic [7:0]           status_s;
  logic                 cmd_wr_s;
  logic                 wd_clr_s;
  logic                 wd_en_s;
  logic                 wd_term_s;
  logic [TIMEOUT_W-1:0] wd_cnt_s;

  mathbox_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr   (wd_clr_s),
    .en    (wd_en_s),
    .cnt   (wd_cnt_s),
    .term  (wd_term_s)
  );

  assign cmd_wr_s = cpu_we && is_cmd(cpu_addr);

  // Status byte as seen before this edge's updates.
  always_comb begin
    status_s                   = 8'h00;
    status_s[STAT_BUSY_BIT]    = busy_q;
    status_s[STAT_TIMEOUT_BIT] = timeout_q;
  end

  // Sequencing: a command write restarts from any state, otherwise walk the FSM.
  always_comb begin
    state_d    = state_q;
    alu_din_d  = alu_din_q;
    pc_start_d = pc_start_q;
    pc_load_d  = 1'b0;
    begin_n_d  = begin_n_q;
    busy_d     = busy_q;
    timeout_d  = timeout_q;
    result_d   = result_q;
    wd_clr_s   = 1'b0;
    wd_en_s    = 1'b0;
    if (cmd_wr_s) begin
      alu_din_d  = cpu_din;
      pc_start_d = cpu_addr[START_W-1:0];
      pc_load_d  = 1'b1;
      begin_n_d  = 1'b1;
      busy_d     = 1'b1;
      timeout_d  = 1'b0;
      state_d    = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_LOAD: begin
          begin_n_d = 1'b0;
          wd_clr_s  = 1'b1;
          state_d   = ST_RUN;
        end
        ST_RUN: begin
          begin_n_d = 1'b0;
          wd_en_s   = 1'b1;
          // A zero count marks the first RUN cycle, where pcen_n is not yet valid.
          if (pcen_n && (wd_cnt_s != {TIMEOUT_W{1'b0}})) begin
            state_d = ST_SETTLE;
          end else if (wd_term_s) begin
            timeout_d = 1'b1;
            state_d   = ST_SETTLE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_SETTLE: begin
          result_d  = alu_result;
          begin_n_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
        default: begin
          begin_n_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      endcase
    end
  end

  // Read mux; a read paired with a command write reports the pre-write status.
  always_comb begin
    cpu_dout_d = cpu_dout_q;
    if (cpu_re) begin
      if (cmd_wr_s) begin
        cpu_dout_d = status_s;
      end else begin
        case (cpu_addr)
          MB_STATUS: cpu_dout_d = status_s;
          MB_RES_LO: cpu_dout_d = result_q[7:0];
          MB_RES_HI: cpu_dout_d = result_q[15:8];
          default:   cpu_dout_d = 8'h00;
        endcase
      end
    end else begin
      cpu_dout_d = cpu_dout_q;
    end
  end

  // All host-interface state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cpu_dout_q <= 8'h00;
      alu_din_q  <= 8'h00;
      pc_start_q <= {START_W{1'b0}};
      pc_load_q  <= 1'b0;
      begin_n_q  <= 1'b1;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      result_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cpu_dout_q <= cpu_dout_d;
      alu_din_q  <= alu_din_d;
      pc_start_q <= pc_start_d;
      pc_load_q  <= pc_load_d;
      begin_n_q  <= begin_n_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      result_q   <= result_d;
    end
  end

  assign cpu_dout = cpu_dout_q;
  assign alu_din  = alu_din_q;
  assign pc_start = pc_start_q;
  assign pc_load  = pc_load_q;
  assign begin_n  = begin_n_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_mathbox_host_if.sv
// Directed bench for mathbox_host_if with a 4-bit watchdog so timeouts are short.
module tb_mathbox_host_if;

  logic        clk;
  logic        reset;
  logic [6:0]  cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_dout;
  logic [7:0]  alu_din;
  logic        pc_load;
  logic [4:0]  pc_start;
  logic        begin_n;
  logic        pcen_n;
  logic [15:0] alu_result;
  logic        busy;
  logic        timeout;

  int n_checks;
  int n_errors;
  logic [7:0] rdata;

  mathbox_host_if #(.TIMEOUT_W(4), .START_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_dout   (cpu_dout),
    .alu_din    (alu_din),
    .pc_load    (pc_load),
    .pc_start   (pc_start),
    .begin_n    (begin_n),
    .pcen_n     (pcen_n),
    .alu_result (alu_result),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_din  = d;
    cpu_we   = 1'b1;
    step();
    cpu_we   = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] d);
    cpu_addr = a;
    cpu_re   = 1'b1;
    step();
    cpu_re   = 1'b0;
    d        = cpu_dout;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    cpu_addr   = 7'h00;
    cpu_din    = 8'h00;
    cpu_we     = 1'b0;
    cpu_re     = 1'b0;
    pcen_n     = 1'b0;
    alu_result = 16'h1234;

    // Reset values
    step();
    step();
    check("rst_begin_n", {15'd0, begin_n}, 16'h0001);
    check("rst_busy", {15'd0, busy}, 16'h0000);
    check("rst_pc_load", {15'd0, pc_load}, 16'h0000);
    check("rst_dout", {8'd0, cpu_dout}, 16'h0000);
    reset = 1'b0;
    step();
    rd(7'h40, rdata);
    check("rst_status", {8'd0, rdata}, 16'h0000);

    // Normal run
    wr(7'h0C, 8'h5A);
    check("run_alu_din", {8'd0, alu_din}, 16'h005A);
    check("run_pc_start", {11'd0, pc_start}, 16'h000C);
    check("run_pc_load1", {15'd0, pc_load}, 16'h0001);
    check("run_begin_n_hi", {15'd0, begin_n}, 16'h0001);
    step();
    check("run_pc_load0", {15'd0, pc_load}, 16'h0000);
    check("run_begin_n_lo", {15'd0, begin_n}, 16'h0000);
    rd(7'h40, rdata);
    check("run_status", {8'd0, rdata}, 16'h0080);
    for (int i = 0; i < 4; i++) step();
    pcen_n     = 1'b1;
    alu_result = 16'hBEEF;
    step();
    check("settle_busy", {15'd0, busy}, 16'h0001);
    step();
    pcen_n = 1'b0;
    check("done_busy", {15'd0, busy}, 16'h0000);
    check("done_begin_n", {15'd0, begin_n}, 16'h0001);
    rd(7'h60, rdata);
    check("res_lo", {8'd0, rdata}, 16'h00EF);
    rd(7'h70, rdata);
    check("res_hi", {8'd0, rdata}, 16'h00BE);
    rd(7'h40, rdata);
    check("done_status", {8'd0, rdata}, 16'h0000);
    rd(7'h41, rdata);
    check("other_off", {8'd0, rdata}, 16'h0000);

    // Write outside the command window is ignored
    wr(7'h20, 8'h77);
    check("ign_busy", {15'd0, busy}, 16'h0000);
    check("ign_pc_load", {15'd0, pc_load}, 16'h0000);
    check("ign_alu_din", {8'd0, alu_din}, 16'h005A);

    // Watchdog timeout: 15 RUN cycles with pcen_n low
    wr(7'h05, 8'h11);
    step();
    for (int i = 0; i < 14; i++) step();
    check("to_pre_flag", {15'd0, timeout}, 16'h0000);
    check("to_pre_busy", {15'd0, busy}, 16'h0001);
    step();
    check("to_flag", {15'd0, timeout}, 16'h0001);
    step();
    check("to_busy", {15'd0, busy}, 16'h0000);
    rd(7'h40, rdata);
    check("to_status", {8'd0, rdata}, 16'h0040);

    // Command with simultaneous read: read sees pre-write status, timeout clears
    alu_result = 16'hCAFE;
    cpu_addr = 7'h07;
    cpu_din  = 8'h22;
    cpu_we   = 1'b1;
    cpu_re   = 1'b1;
    step();
    cpu_we   = 1'b0;
    cpu_re   = 1'b0;
    check("wr_rd_status", {8'd0, cpu_dout}, 16'h0040);
    check("clr_timeout", {15'd0, timeout}, 16'h0000);
    check("clr_busy", {15'd0, busy}, 16'h0001);
    step();
    // pcen_n glitch during the first RUN cycle must be ignored
    pcen_n = 1'b1;
    step();
    pcen_n = 1'b0;
    check("glitch_busy", {15'd0, busy}, 16'h0001);
    step();
    check("glitch_busy2", {15'd0, busy}, 16'h0001);
    check("glitch_begin_n", {15'd0, begin_n}, 16'h0000);

    // Restart during RUN
    wr(7'h03, 8'h33);
    check("rs_begin_n_hi", {15'd0, begin_n}, 16'h0001);
    check("rs_pc_load", {15'd0, pc_load}, 16'h0001);
    check("rs_pc_start", {11'd0, pc_start}, 16'h0003);
    check("rs_alu_din", {8'd0, alu_din}, 16'h0033);
    rd(7'h60, rdata);
    check("rs_old_res", {8'd0, rdata}, 16'h00EF);
    check("rs_begin_n_lo", {15'd0, begin_n}, 16'h0000);
    check("rs_pc_load0", {15'd0, pc_load}, 16'h0000);
    step();
    pcen_n = 1'b1;
    step();
    step();
    pcen_n = 1'b0;
    check("rs_done", {15'd0, busy}, 16'h0000);
    rd(7'h70, rdata);
    check("rs_res_hi", {8'd0, rdata}, 16'h00CA);
    rd(7'h60, rdata);
    check("rs_res_lo", {8'd0, rdata}, 16'h00FE);

    // Asynchronous reset mid-run
    wr(7'h10, 8'h44);
    step();
    step();
    check("ar_pre_begin_n", {15'd0, begin_n}, 16'h0000);
    #3;
    reset = 1'b1;
    #1;
    check("ar_begin_n", {15'd0, begin_n}, 16'h0001);
    check("ar_busy", {15'd0, busy}, 16'h0000);
    check("ar_alu_din", {8'd0, alu_din}, 16'h0000);
    #1;
    reset = 1'b0;
    step();
    rd(7'h60, rdata);
    check("ar_res_clr", {8'd0, rdata}, 16'h0000);
    alu_result = 16'h0102;
    wr(7'h01, 8'h55);
    step();
    check("ar_new_begin_n", {15'd0, begin_n}, 16'h0000);
    check("ar_new_pc_start", {11'd0, pc_start}, 16'h0001);
    step();
    pcen_n = 1'b1;
    step();
    step();
    pcen_n = 1'b0;
    check("ar_new_done", {15'd0, busy}, 16'h0000);
    rd(7'h60, rdata);
    check("ar_new_res", {8'd0, rdata}, 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
